pulse_burst_sequencer: RTL and testbench
========================================

# pulse_burst_sequencer

Controller that sequences the DDS datapath of the digital synthesizer into a burst of radar impulses. On a start request it latches the burst configuration and checks it. It then produces the impulse gating (`GEN_EN`) and the per-impulse phase-restart strobe (`IMP_START`) that the synthesizer core and its LFM/PSK/noise modulators consume. It sits between the control interface (start/config registers) and `digital_synthesizer_v1`.

## Interface
- `CLKS_PER_US`, default 500: CLK cycles per microsecond (500 MHz system clock); range 2..1023.
- `CLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-low reset.
- `SIGN_START_GEN`  in  1  start request; its rising edge starts a burst.
- `STOP`  in  1  synchronous abort, active-high.
- `SIGNAL_TYPE`  in  2  1=LFM, 2=PSK, 3=noise; 0 is invalid.
- `T_IMPULSE`  in  10  impulse width, µs.
- `T_PERIOD`  in  13  repetition period, µs.
- `NUM_OF_IMP`  in  5  impulses per burst; 0 is invalid.
- `GEN_EN`  out  1  high while an impulse is being radiated.
- `IMP_START`  out  1  one-cycle strobe on the first cycle of each impulse.
- `SIG_TYPE_Q`  out  2  latched signal type, held for the whole burst.
- `IMP_INDEX`  out  5  index of the current impulse, starting at 0.
- `BUSY`  out  1  burst in progress.
- `DONE`  out  1  one-cycle strobe when a burst completes normally.
- `CFG_ERR`  out  1  one-cycle strobe when a start request is rejected.

## Operation
- Edge detect: `start = SIGN_START_GEN & ~s_d`, where `s_d` is the registered input.
  - `s_d` resets to 1, so an input held high through reset does not start a burst.
- FSM states: IDLE, PULSE, GAP, FIN.
- IDLE, on `start`:
  - Config is valid when `SIGNAL_TYPE!=0`, `NUM_OF_IMP!=0`, `T_IMPULSE!=0` and `T_PERIOD>T_IMPULSE`.
  - Valid: latch all config into shadow registers and go to PULSE.
  - Invalid: assert `CFG_ERR` for one cycle and stay in IDLE.
- PULSE:
  - Lasts `T_IMPULSE*CLKS_PER_US` cycles, then goes to GAP.
- GAP:
  - Lasts `(T_PERIOD−T_IMPULSE)*CLKS_PER_US` cycles.
  - Then goes to PULSE with `IMP_INDEX+1`; after the last impulse it goes to FIN.
  - The last period includes its full gap.
- FIN: one cycle with `DONE=1`, then IDLE.
- Durations are counted with a prescaler (0..`CLKS_PER_US`−1) plus a 13-bit µs counter. No multiplier is used.
  - The gap length is computed once at latch time, as a 13-bit unsigned value.
- Output values by state:
  - `GEN_EN` is 1 only in PULSE.
  - `BUSY` is 1 in PULSE, GAP and FIN.
  - `IMP_START` is 1 on the first PULSE cycle of each impulse.
- While BUSY, `start` edges and config-input changes are ignored; only the shadow copies are used.
- `STOP`:
  - In any non-IDLE state, the next state is IDLE; `GEN_EN` and `BUSY` are 0 in the following cycle and `DONE` is not asserted.
  - `STOP` takes priority over every FSM transition.
  - `STOP` together with `start` in IDLE: the start is dropped.
- Reset: every output is 0, the FSM is in IDLE, all counters are cleared and `s_d` is 1.
  - A reset applied mid-burst terminates the burst without a `DONE` strobe.

## Timing
- Cycle 0 is the first edge at which `start` is sampled high with a valid config.
- Cycle 1: `GEN_EN` and `IMP_START` high, `BUSY` high, `IMP_INDEX`=0.
- With P = `T_PERIOD*CLKS_PER_US` and W = `T_IMPULSE*CLKS_PER_US`:
  - impulse k spans cycles 1+kP .. kP+W;
  - `DONE` occurs at cycle 1+N·P;
  - `BUSY` falls at cycle 2+N·P.
- A new burst can start from the cycle after `BUSY` falls.
- `CFG_ERR` is asserted in cycle 1 after an invalid start is sampled.
- `IMP_INDEX` updates on the same edge that raises `IMP_START`.
- All outputs are registered.

## Structure
- A shared package `synth_pkg` holds:
  - the signal-type constants `_LFM_SIGNAL_TYPE`, `_PSK_SIGNAL_TYPE` and `_NOISE_SIGNAL_TYPE`;
  - the FSM state encoding;
  - the config field widths (10/13/5/2).
- One sub-module, `us_timer`: the prescaler plus the µs down-counter, with `load`/`len` inputs and an `expire` output.
  - It is instantiated once and reloaded on each PULSE/GAP entry.

## Test plan
- `CLKS_PER_US`=4, `T_IMPULSE`=2, `T_PERIOD`=5, `NUM_OF_IMP`=3, type 1 ->
  - `GEN_EN` high in cycles 1–8, 21–28 and 41–48;
  - `IMP_START` at cycles 1, 21 and 41;
  - `DONE` at cycle 61;
  - `BUSY` low from cycle 62.
- `T_IMPULSE`=10, `T_PERIOD`=2 (also separately `NUM_OF_IMP`=0 and `SIGNAL_TYPE`=0) -> `CFG_ERR` one cycle at cycle 1; `GEN_EN` and `BUSY` stay 0.
- During the burst of test 1: toggle `SIGN_START_GEN` every 10 cycles and change `T_IMPULSE` to 1 at cycle 5 -> waveform identical to test 1; `SIG_TYPE_Q` stays 1.
- `STOP` pulse at cycle 23 of test 1 -> `GEN_EN`=0 and `BUSY`=0 from cycle 24; no `DONE`; a new edge at cycle 30 restarts with `IMP_INDEX`=0.
- `RESET` low at cycle 15 with `SIGN_START_GEN` held high through release -> all outputs 0; no restart until `SIGN_START_GEN` goes low then high.
- `T_IMPULSE`=1, `T_PERIOD`=2, `NUM_OF_IMP`=31, `CLKS_PER_US`=4 -> `IMP_INDEX` steps 0..30 every 8 cycles; `DONE` at cycle 249.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer control path: signal-type codes,
// burst sequencer state encoding, config field widths and the latched
// burst configuration record.
package synth_pkg;

    localparam int unsigned SIG_TYPE_W = 2;
    localparam int unsigned T_IMP_W    = 10;
    localparam int unsigned T_PER_W    = 13;
    localparam int unsigned NUM_IMP_W  = 5;
    localparam int unsigned US_CNT_W   = 13;

    // Modulation selected by SIGNAL_TYPE; code 0 is reserved as invalid.
    localparam logic [SIG_TYPE_W-1:0] _LFM_SIGNAL_TYPE   = 2'd1;
    localparam logic [SIG_TYPE_W-1:0] _PSK_SIGNAL_TYPE   = 2'd2;
    localparam logic [SIG_TYPE_W-1:0] _NOISE_SIGNAL_TYPE = 2'd3;

    // Burst sequencer state encoding.
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_PULSE = 2'd1;
    localparam logic [STATE_W-1:0] ST_GAP   = 2'd2;
    localparam logic [STATE_W-1:0] ST_FIN   = 2'd3;

    // Shadow copy of the burst configuration taken at start time.
    typedef struct packed {
        logic [SIG_TYPE_W-1:0] sig_type;
        logic [T_IMP_W-1:0]    t_imp;
        logic [US_CNT_W-1:0]   gap_len;
        logic [NUM_IMP_W-1:0]  num_imp;
    } burst_cfg_t;

    // A burst needs a known modulation, at least one impulse, a non-zero
    // impulse width and a period strictly longer than the impulse.
    function automatic logic cfg_valid(
        input logic [SIG_TYPE_W-1:0] sig_type,
        input logic [T_IMP_W-1:0]    t_imp,
        input logic [T_PER_W-1:0]    t_per,
        input logic [NUM_IMP_W-1:0]  num_imp
    );
        logic type_ok;
        type_ok = (sig_type == _LFM_SIGNAL_TYPE) ||
                  (sig_type == _PSK_SIGNAL_TYPE) ||
                  (sig_type == _NOISE_SIGNAL_TYPE);
        return type_ok && (num_imp != '0) && (t_imp != '0) &&
               (t_per > T_PER_W'(t_imp));
    endfunction

endpackage

// File: rtl/pulse_burst_sequencer_if.sv
// Control/status bundle between the start/config registers and the burst
// sequencer.
//   master: drives start, abort and burst configuration, observes status.
//   slave : the sequencer; consumes config, produces gating and status.
interface pulse_burst_sequencer_if;
    import synth_pkg::*;

    logic                  SIGN_START_GEN;
    logic                  STOP;
    logic [SIG_TYPE_W-1:0] SIGNAL_TYPE;
    logic [T_IMP_W-1:0]    T_IMPULSE;
    logic [T_PER_W-1:0]    T_PERIOD;
    logic [NUM_IMP_W-1:0]  NUM_OF_IMP;

    logic                  GEN_EN;
    logic                  IMP_START;
    logic [SIG_TYPE_W-1:0] SIG_TYPE_Q;
    logic [NUM_IMP_W-1:0]  IMP_INDEX;
    logic                  BUSY;
    logic                  DONE;
    logic                  CFG_ERR;

    modport master (
        output SIGN_START_GEN, STOP, SIGNAL_TYPE, T_IMPULSE, T_PERIOD, NUM_OF_IMP,
        input  GEN_EN, IMP_START, SIG_TYPE_Q, IMP_INDEX, BUSY, DONE, CFG_ERR
    );

    modport slave (
        input  SIGN_START_GEN, STOP, SIGNAL_TYPE, T_IMPULSE, T_PERIOD, NUM_OF_IMP,
        output GEN_EN, IMP_START, SIG_TYPE_Q, IMP_INDEX, BUSY, DONE, CFG_ERR
    );
endinterface

// File: rtl/pulse_burst_sequencer_us_timer.sv
// Microsecond interval timer: a 0..CLKS_PER_US-1 prescaler feeding a
// microsecond down-counter. A load starts an interval of len microseconds;
// expire is high during the last clock cycle of that interval.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : (re)start an interval this cycle
//   len        : interval length in microseconds (must be >= 1)
//   expire     : registered, high on the final cycle of the interval
module us_timer
    import synth_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [US_CNT_W-1:0] len,
    output logic                expire
);

    localparam int unsigned PRE_W = $clog2(CLKS_PER_US);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [US_CNT_W-1:0] cnt_q, cnt_d;
    logic                expire_q, expire_d;

    // Count down one microsecond per prescaler wrap; park at zero when done.
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (load) begin
            pre_d = '0;
            cnt_d = len;
        end else if (cnt_q != '0) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                cnt_d = cnt_q - US_CNT_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
        // Looking at the next counter state keeps expire registered yet aligned.
        expire_d = (cnt_d == US_CNT_W'(1)) && (pre_d == PRE_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/pulse_burst_sequencer.sv
// Burst sequencer for the DDS datapath: on a rising start edge it checks and
// latches the burst configuration, then gates the synthesizer (GEN_EN) for
// NUM_OF_IMP impulses of T_IMPULSE us every T_PERIOD us, strobing IMP_START
// at each impulse start.
//   CLK, RESET : system clock, synchronous active-low reset
//   bus        : slave side of pulse_burst_sequencer_if (start/stop/config in,
//                GEN_EN/IMP_START/SIG_TYPE_Q/IMP_INDEX/BUSY/DONE/CFG_ERR out)
module pulse_burst_sequencer
    import synth_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = 500
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pulse_burst_sequencer_if.slave bus
);

    logic [STATE_W-1:0]   state_q, state_d;
    logic                 start_in_q;
    burst_cfg_t           cfg_q, cfg_d;
    logic [NUM_IMP_W-1:0] idx_q, idx_d;
    logic                 gen_en_q, gen_en_d;
    logic                 imp_start_q, imp_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 start_c;
    logic                 cfg_ok_c;
    logic                 load_c;
    logic [US_CNT_W-1:0]  len_c;
    logic                 expire;

    // Rising edge of the start request; the delayed copy resets high so a
    // request held through reset is not taken as a new edge.
    assign start_c  = bus.SIGN_START_GEN & ~start_in_q;
    assign cfg_ok_c = cfg_valid(bus.SIGNAL_TYPE, bus.T_IMPULSE, bus.T_PERIOD, bus.NUM_OF_IMP);

    us_timer #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_us_timer (
        .clk    (CLK),
        .rst_n  (RESET),
        .load   (load_c),
        .len    (len_c),
        .expire (expire)
    );

    // Next state, shadow config, impulse index and timer reload.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        idx_d     = idx_q;
        load_c    = 1'b0;
        len_c     = US_CNT_W'(cfg_q.t_imp);
        cfg_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c && !bus.STOP) begin
                    if (cfg_ok_c) begin
                        state_d        = ST_PULSE;
                        cfg_d.sig_type = bus.SIGNAL_TYPE;
                        cfg_d.t_imp    = bus.T_IMPULSE;
                        cfg_d.gap_len  = US_CNT_W'(bus.T_PERIOD) - US_CNT_W'(bus.T_IMPULSE);
                        cfg_d.num_imp  = bus.NUM_OF_IMP;
                        idx_d          = '0;
                        load_c         = 1'b1;
                        len_c          = US_CNT_W'(bus.T_IMPULSE);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                if (expire) begin
                    state_d = ST_GAP;
                    load_c  = 1'b1;
                    len_c   = cfg_q.gap_len;
                end
            end
            ST_GAP: begin
                if (expire) begin
                    if (idx_q == cfg_q.num_imp - NUM_IMP_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_PULSE;
                        idx_d   = idx_q + NUM_IMP_W'(1);
                        load_c  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition of a running burst.
        if (bus.STOP && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            load_c  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they flop with it.
    always_comb begin
        gen_en_d    = (state_d == ST_PULSE);
        imp_start_d = (state_d == ST_PULSE) && (state_q != ST_PULSE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            start_in_q  <= 1'b1;
            cfg_q       <= '0;
            idx_q       <= '0;
            gen_en_q    <= 1'b0;
            imp_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_in_q  <= bus.SIGN_START_GEN;
            cfg_q       <= cfg_d;
            idx_q       <= idx_d;
            gen_en_q    <= gen_en_d;
            imp_start_q <= imp_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.GEN_EN     = gen_en_q;
    assign bus.IMP_START  = imp_start_q;
    assign bus.SIG_TYPE_Q = cfg_q.sig_type;
    assign bus.IMP_INDEX  = idx_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.CFG_ERR    = cfg_err_q;

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Self-checking bench for pulse_burst_sequencer with CLKS_PER_US = 4.
// Cycle c is the value sampled at clock edge c, where edge 0 samples the start.
module tb_pulse_burst_sequencer;

    localparam int CPU = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pulse_burst_sequencer_if bus();

    pulse_burst_sequencer #(
        .CLKS_PER_US (CPU)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int sig;
        int ti;
        int tp;
        int n;
        bit valid;
        int done_cyc;
    } vec_t;

    typedef struct {
        bit gen;
        bit st;
        bit busy;
        bit done;
        int idx;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, got, exp);
        end
    endtask

    // Expected outputs of an undisturbed burst, from period arithmetic.
    function automatic exp_t model(input int c, input int w, input int p, input int n);
        exp_t e;
        e.gen = 0; e.st = 0; e.busy = 0; e.done = 0; e.idx = 0;
        if (c >= 1 && c <= n * p) begin
            e.busy = 1;
            e.gen  = ((c - 1) % p) < w;
            e.st   = ((c - 1) % p) == 0;
            e.idx  = (c - 1) / p;
        end else if (c == n * p + 1) begin
            e.busy = 1;
            e.done = 1;
            e.idx  = n - 1;
        end
        return e;
    endfunction

    task automatic idle(input int n);
        bus.SIGN_START_GEN = 1'b0;
        bus.STOP           = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, "/GEN_EN"},     c, int'(bus.GEN_EN),     0);
        chk({tag, "/IMP_START"},  c, int'(bus.IMP_START),  0);
        chk({tag, "/BUSY"},       c, int'(bus.BUSY),       0);
        chk({tag, "/DONE"},       c, int'(bus.DONE),       0);
        chk({tag, "/CFG_ERR"},    c, int'(bus.CFG_ERR),    0);
        chk({tag, "/IMP_INDEX"},  c, int'(bus.IMP_INDEX),  0);
        chk({tag, "/SIG_TYPE_Q"}, c, int'(bus.SIG_TYPE_Q), 0);
    endtask

    // Starts a burst at the current negedge (cycle 0) and checks ncyc cycles.
    // stop_at: cycle whose edge samples STOP (0 = none); restart_at: cycle
    // whose edge samples a fresh start after the stop; perturb: wiggle start
    // and config inputs mid-burst.
    task automatic run_burst(input vec_t v, input int stop_at, input int restart_at,
                             input bit perturb, input int ncyc, input string tag);
        int   w, p, n, done_seen;
        exp_t e;
        bit   cerr;
        w = v.ti * CPU;
        p = v.tp * CPU;
        n = v.n;
        done_seen = 0;
        bus.SIGNAL_TYPE    = 2'(v.sig);
        bus.T_IMPULSE      = 10'(v.ti);
        bus.T_PERIOD       = 13'(v.tp);
        bus.NUM_OF_IMP     = 5'(v.n);
        bus.STOP           = 1'b0;
        bus.SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            e.gen = 0; e.st = 0; e.busy = 0; e.done = 0; e.idx = 0;
            cerr = 0;
            if (!v.valid) cerr = (c == 1);
            else if (restart_at > 0 && c > restart_at) e = model(c - restart_at, w, p, n);
            else if (!(stop_at > 0 && c > stop_at)) e = model(c, w, p, n);
            chk({tag, "/GEN_EN"},    c, int'(bus.GEN_EN),    int'(e.gen));
            chk({tag, "/IMP_START"}, c, int'(bus.IMP_START), int'(e.st));
            chk({tag, "/BUSY"},      c, int'(bus.BUSY),      int'(e.busy));
            chk({tag, "/DONE"},      c, int'(bus.DONE),      int'(e.done));
            chk({tag, "/CFG_ERR"},   c, int'(bus.CFG_ERR),   int'(cerr));
            if (e.busy) begin
                chk({tag, "/IMP_INDEX"},  c, int'(bus.IMP_INDEX),  e.idx);
                chk({tag, "/SIG_TYPE_Q"}, c, int'(bus.SIG_TYPE_Q), v.sig);
            end
            if (bus.DONE && done_seen == 0) done_seen = c;
            // Inputs for edge c.
            bus.STOP = (c == stop_at);
            if (restart_at > 0)
                bus.SIGN_START_GEN = (c >= restart_at) || (c < stop_at + 2);
            if (perturb) begin
                if (c % 10 == 0) bus.SIGN_START_GEN = ~bus.SIGN_START_GEN;
                if (c == 5) begin
                    bus.T_IMPULSE   = 10'd1;
                    bus.SIGNAL_TYPE = 2'd3;
                end
            end
        end
        if (v.done_cyc >= 0) chk({tag, "/done_cycle"}, ncyc, done_seen, v.done_cyc);
    endtask

    vec_t tbl[9];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t v;
        int   w, p;
        exp_t e;

        //            sig ti  tp  n   valid done_cyc
        tbl[0] = '{sig:1, ti:2,  tp:5, n:3,  valid:1, done_cyc:61};
        tbl[1] = '{sig:1, ti:10, tp:2, n:3,  valid:0, done_cyc:0};
        tbl[2] = '{sig:2, ti:2,  tp:5, n:0,  valid:0, done_cyc:0};
        tbl[3] = '{sig:0, ti:2,  tp:5, n:3,  valid:0, done_cyc:0};
        tbl[4] = '{sig:3, ti:1,  tp:2, n:2,  valid:1, done_cyc:17};
        tbl[5] = '{sig:2, ti:3,  tp:4, n:1,  valid:1, done_cyc:17};
        tbl[6] = '{sig:1, ti:0,  tp:5, n:1,  valid:0, done_cyc:0};
        tbl[7] = '{sig:1, ti:4,  tp:4, n:1,  valid:0, done_cyc:0};
        tbl[8] = '{sig:1, ti:1,  tp:2, n:31, valid:1, done_cyc:249};

        rst_n              = 1'b0;
        bus.SIGN_START_GEN = 1'b0;
        bus.STOP           = 1'b0;
        bus.SIGNAL_TYPE    = '0;
        bus.T_IMPULSE      = '0;
        bus.T_PERIOD       = '0;
        bus.NUM_OF_IMP     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset", 0);
        rst_n = 1'b1;
        idle(3);

        // Vector table.
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            run_burst(v, 0, 0, 0, v.valid ? (v.n * v.tp * CPU + 3) : 4, $sformatf("tbl%0d", i));
            idle(3);
        end

        // Start edges and config changes during a burst are ignored.
        run_burst(tbl[0], 0, 0, 1, 63, "ignore");
        idle(3);

        // Abort at cycle 23, fresh start edge at cycle 30.
        v = tbl[0];
        v.done_cyc = -1;
        run_burst(v, 23, 30, 0, 93, "stop");
        idle(3);

        // Reset mid-burst with the start request held high through release.
        v = tbl[0];
        w = v.ti * CPU;
        p = v.tp * CPU;
        bus.SIGNAL_TYPE    = 2'(v.sig);
        bus.T_IMPULSE      = 10'(v.ti);
        bus.T_PERIOD       = 13'(v.tp);
        bus.NUM_OF_IMP     = 5'(v.n);
        bus.SIGN_START_GEN = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 15) begin
                e = model(c, w, p, v.n);
                chk("rst_mid/GEN_EN", c, int'(bus.GEN_EN), int'(e.gen));
                chk("rst_mid/BUSY",   c, int'(bus.BUSY),   int'(e.busy));
            end else begin
                chk_all_zero("rst_mid", c);
            end
            if (c == 15) rst_n = 1'b0;
            if (c == 17) rst_n = 1'b1;
        end
        idle(3);
        run_burst(tbl[0], 0, 0, 0, 63, "after_rst");
        idle(3);

        // Randomized bursts, some aborted part way.
        for (int r = 0; r < 10; r++) begin
            int stop_at;
            v.sig      = int'($urandom_range(1, 3));
            v.ti       = int'($urandom_range(1, 4));
            v.tp       = v.ti + int'($urandom_range(1, 4));
            v.n        = int'($urandom_range(1, 4));
            v.valid    = 1;
            v.done_cyc = -1;
            p = v.tp * CPU;
            stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, v.n * p)) : 0;
            run_burst(v, stop_at, 0, 0, v.n * p + 3, $sformatf("rand%0d", r));
            idle(int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
